// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED matrix scan controller.
//   LED_COUNT/LEVEL_W/ROW_W/COL_W : matrix geometry and brightness width
//   level_t, addr_t, wr_req_t      : write-port payload types
//   commit_state_e                 : commit FSM encoding
//   slot_decode()                  : slot index -> {row, col}
package led_pkg;
  localparam int LED_COUNT = 16;
  localparam int LEVEL_W   = 4;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 2;
  localparam int ADDR_W    = ROW_W + COL_W;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef struct packed {
    addr_t  addr;
    level_t level;
  } wr_req_t;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} commit_state_e;

  // Upper bits pick the row (cathode), lower bits the column (anode).
  function automatic logic [ROW_W+COL_W-1:0] slot_decode(input addr_t s);
    return {s[ADDR_W-1 -: ROW_W], s[COL_W-1:0]};
  endfunction
endpackage

// File: rtl/led_scan_ctrl_if.sv
// led_scan_ctrl_if: write/commit handshake between the register block
// (master) and the scan controller (slave).
//   wr_valid/wr_ready/wr_addr/wr_level : shadow-buffer write port
//   commit/commit_done                 : publish request and completion pulse
interface led_scan_ctrl_if;
  import led_pkg::*;

  logic   wr_valid;
  logic   wr_ready;
  addr_t  wr_addr;
  level_t wr_level;
  logic   commit;
  logic   commit_done;

  modport master (
    output wr_valid, wr_addr, wr_level, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_level, commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered frame of LED_COUNT brightness levels.
//   clk, rst_n   : clock, async active-low reset (clears both buffers)
//   wr_en_i      : write wr_req_i.level into shadow[wr_req_i.addr]
//   wr_req_i     : write payload
//   publish_i    : copy the whole shadow buffer into active in one cycle
//   active_o     : active buffer, read by the scan decode
module led_frame_buffer
  import led_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en_i,
  input  wr_req_t                            wr_req_i,
  input  logic                               publish_i,
  output logic [LED_COUNT-1:0][LEVEL_W-1:0]  active_o
);

  logic [LED_COUNT-1:0][LEVEL_W-1:0] shadow_q, shadow_d;
  logic [LED_COUNT-1:0][LEVEL_W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i) shadow_d[wr_req_i.addr] = wr_req_i.level;
    // Copy uses the pre-write shadow; writes and publish never coincide
    // because the write port is closed while a publish is pending.
    if (publish_i) active_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 4x4 LED matrix scanner with PWM dimming and frame-aligned
// publishing of a double-buffered frame.
//   DWELL_CYCLES : clocks per LED slot (multiple of 16, >= 32)
//   clk, rst_n   : clock, async active-low reset
//   bus          : write/commit handshake (slave side)
//   frame_start  : pulse at the first cycle of every frame
//   aled         : anode select, active-low, one column at a time
//   kled_tri     : cathode output-enable, one row when the slot is lit
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int DWELL_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_scan_ctrl_if.slave        bus,
  output logic                  frame_start,
  output logic [3:0]            aled,
  output logic [3:0]            kled_tri
);

  localparam int D_W      = $clog2(DWELL_CYCLES);
  localparam int STEP_DIV = DWELL_CYCLES / 16;

  logic [D_W-1:0] d_q, d_d;
  addr_t          s_q, s_d;
  logic           d_last, boundary;

  commit_state_e  state_q, state_d;
  logic           publish;
  logic           wr_fire;

  logic [LED_COUNT-1:0][LEVEL_W-1:0] active;
  wr_req_t        wr_req;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  level_t           step;
  logic             lit;

  logic [3:0] aled_q, aled_d;
  logic [3:0] kled_q, kled_d;
  logic       frame_start_q, commit_done_q;

  // ---------------- slot / dwell counters ----------------
  assign d_last   = (d_q == D_W'(DWELL_CYCLES - 1));
  assign boundary = d_last && (s_q == addr_t'(LED_COUNT - 1));
  assign d_d      = d_last ? '0 : d_q + 1'b1;
  assign s_d      = d_last ? s_q + 1'b1 : s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      s_q <= '0;
    end else begin
      d_q <= d_d;
      s_q <= s_d;
    end
  end

  // ---------------- commit FSM ----------------
  // A commit seen in the boundary cycle while IDLE only arms PENDING, so it
  // waits a full frame; commits while PENDING are dropped.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.commit) state_d = PENDING;
      PENDING: if (boundary) begin
                 publish = 1'b1;
                 state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.wr_ready = (state_q == IDLE);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign wr_req       = '{addr: bus.wr_addr, level: bus.wr_level};

  led_frame_buffer u_fb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_req_i  (wr_req),
    .publish_i (publish),
    .active_o  (active)
  );

  // ---------------- slot decode ----------------
  // Step 0 of every slot stays dark so the previous cathode can discharge.
  always_comb begin
    {row, col} = slot_decode(s_q);
    step       = LEVEL_W'(d_q / STEP_DIV);
    lit        = (step != '0) && (step <= active[s_q]);
    aled_d     = ~(4'b0001 << col);
    kled_d     = lit ? (4'b0001 << row) : 4'b0000;
  end

  // Publish lands on the boundary edge, so both pulses appear in the first
  // cycle of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aled_q        <= 4'b1111;
      kled_q        <= 4'b0000;
      frame_start_q <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      aled_q        <= aled_d;
      kled_q        <= kled_d;
      frame_start_q <= boundary;
      commit_done_q <= publish;
    end
  end

  assign aled            = aled_q;
  assign kled_tri        = kled_q;
  assign frame_start     = frame_start_q;
  assign bus.commit_done = commit_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
module tb_led_scan_ctrl;
  localparam int DW  = 32;
  localparam int P   = 16 * DW;
  localparam int DIV = DW / 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start;
  logic [3:0] aled, kled_tri;

  led_scan_ctrl_if bus();

  led_scan_ctrl #(.DWELL_CYCLES(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_start (frame_start),
    .aled        (aled),
    .kled_tri    (kled_tri)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase (0..P-1) the scanner is in before the next
  // edge, the two buffers, and whether a publish is outstanding.
  int         ph;
  logic [3:0] m_sh [16];
  logic [3:0] m_act[16];
  bit         m_pend;
  int         lit_cyc;
  int         cd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_sh[i]  = 4'd0;
      m_act[i] = 4'd0;
    end
  endtask

  // Brightness budget: each level unit is DIV lit cycles per frame.
  function automatic int exp_lit();
    int sum = 0;
    for (int i = 0; i < 16; i++) sum += int'(m_act[i]) * DIV;
    return sum;
  endfunction

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input bit v, input logic [3:0] a, input logic [3:0] l, input bit c);
    int s, d, st;
    logic [3:0] ea, ek;
    bit efs, ecd;
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_level = l;
    bus.commit   = c;
    chk("wr_ready", bus.wr_ready, !m_pend);
    s  = ph / DW;
    d  = ph % DW;
    st = d / DIV;
    ea = ~(4'b0001 << (s % 4));
    ek = (st >= 1 && st <= int'(m_act[s])) ? (4'b0001 << (s / 4)) : 4'b0000;
    efs = (ph == P - 1);
    ecd = efs && m_pend;
    if (m_pend) begin
      if (ph == P - 1) begin
        for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
        m_pend = 1'b0;
      end
    end else begin
      if (v) m_sh[a] = l;
      if (c) m_pend = 1'b1;
    end
    ph = (ph + 1) % P;
    @(posedge clk);
    #1;
    chk("aled", aled, ea);
    chk("kled_tri", kled_tri, ek);
    chk("frame_start", frame_start, efs);
    chk("commit_done", bus.commit_done, ecd);
    if (kled_tri != 4'b0000) lit_cyc++;
    if (bus.commit_done) cd_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic run_until_cd(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 2 * P) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      n++;
      got = bus.commit_done;
    end
    chk("cd_timeout", got, 1'b1);
  endtask

  task automatic frame_lit(input string tag);
    lit_cyc = 0;
    idle(P);
    chk(tag, lit_cyc, exp_lit());
  endtask

  initial begin
    int n, first;
    logic [3:0] rl;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_level = 4'd0;
    bus.commit   = 1'b0;
    model_reset();
    lit_cyc = 0;
    cd_cnt  = 0;

    // Reset held: outputs idle even with write traffic.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      bus.wr_valid = i[0];
      bus.wr_addr  = 4'(i);
      bus.wr_level = 4'hF;
      bus.commit   = i[1];
      @(negedge clk);
      chk("rst_aled", aled, 4'b1111);
      chk("rst_kled", kled_tri, 4'b0000);
      chk("rst_wr_ready", bus.wr_ready, 1'b1);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_commit_done", bus.commit_done, 1'b0);
    end
    bus.wr_valid = 1'b0;
    bus.commit   = 1'b0;
    rst_n = 1'b1;

    // First frame_start a full frame after release.
    first = 0;
    for (int k = 1; k <= P; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      if (frame_start && first == 0) first = k;
    end
    chk("first_frame_start", first, P);

    // Single LED at full brightness.
    idle(37);
    cyc(1'b1, 4'd5, 4'd15, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    run_until_cd(n);
    frame_lit("lit_single");
    chk("lit_single_30", lit_cyc, 30);

    // PWM level 1 on LED 0, LED 5 back to off.
    cyc(1'b1, 4'd0, 4'd1, 1'b0);
    cyc(1'b1, 4'd5, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    run_until_cd(n);
    frame_lit("lit_pwm");
    chk("lit_pwm_2", lit_cyc, 2);

    // Writes and a second commit while pending are dropped.
    idle(100);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    cyc(1'b1, 4'd3, 4'd9, 1'b0);
    cyc(1'b1, 4'd3, 4'd9, 1'b1);
    cd_cnt = 0;
    run_until_cd(n);
    frame_lit("lit_pending");
    chk("single_commit_done", cd_cnt, 1);

    // Write and commit in the same cycle: publish covers the write.
    idle(50);
    rl = 4'($urandom_range(1, 15));
    cyc(1'b1, 4'd7, rl, 1'b1);
    run_until_cd(n);
    frame_lit("lit_same_cycle");

    // Commit landing on the boundary cycle waits a whole frame.
    cyc(1'b1, 4'd10, 4'd12, 1'b0);
    while (ph != P - 1) cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    run_until_cd(n);
    chk("boundary_latency", n, P);

    // Randomized traffic.
    for (int i = 0; i < 4 * P; i++)
      cyc($urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom), $urandom_range(0, 199) == 0);

    // Async reset mid-frame while pending in slot 9.
    if (m_pend) run_until_cd(n);
    cyc(1'b1, 4'd9, 4'd15, 1'b0);
    while (ph != 9 * DW + 5) cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_aled", aled, 4'b1111);
    chk("async_kled", kled_tri, 4'b0000);
    chk("async_wr_ready", bus.wr_ready, 1'b1);
    chk("async_commit_done", bus.commit_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cd_cnt = 0;
    frame_lit("lit_after_reset");
    chk("lit_after_reset_zero", lit_cyc, 0);
    idle(P);
    chk("no_cd_after_reset", cd_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
